// File: rtl/maybe_stream_fifo.sv
// maybe_stream_fifo: buffers a Maybe-encoded stream (tag + payload) in a
// DEPTH-entry circular FIFO and emits a registered one-cycle Just pulse per pop.
// Nothing inputs never touch storage or pointers. With the macro
// MAYBE_STREAM_FIFO_DROP_CNT_EN defined, a saturating 16-bit counter of items
// dropped at full is exposed on __out3; otherwise drops are silent.
module maybe_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  __in0,
  input  logic          __in1,
  input  logic          __in2,
  output logic          __out0,
  output logic [W-1:0]  __out1,
  output logic [CW-1:0] __out2
`ifdef MAYBE_STREAM_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]   __out3
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_vld_p1;
  logic [W-1:0]  r_data_p1;

  logic          w_full;
  logic          w_pop_ok;
  logic          w_push;

  // Handshake decode: a pop needs something stored; a push needs space or a
  // concurrent pop that frees the slot the write pointer is sitting on.
  always_comb begin
    w_full   = (r_count == CW'(DEPTH));
    w_pop_ok = __in2 & (r_count != '0);
    w_push   = __in1 & (~w_full | w_pop_ok);
  end

  // Storage write; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= __in0;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  // Occupancy tracks push minus pop; simultaneous push and pop leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: Just for exactly one cycle per pop, payload zeroed otherwise
  // so stale data never leaks out under a Nothing tag. The read sees the old
  // slot contents even when a full-FIFO push overwrites that slot this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1  <= w_pop_ok;
      r_data_p1 <= w_pop_ok ? r_mem[r_rptr] : '0;
    end
  end

  assign __out0 = r_vld_p1;
  assign __out1 = r_data_p1;
  assign __out2 = r_count;

`ifdef MAYBE_STREAM_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic        w_drop;

  assign w_drop = __in1 & w_full & ~w_pop_ok;

  // Saturating count of Just items refused because the FIFO was full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign __out3 = r_drop_cnt;
`endif

endmodule

// File: tb/tb_maybe_stream_fifo.sv
// Scoreboard bench for maybe_stream_fifo (W=8, DEPTH=4). A queue-based model
// predicts each edge's output; a negedge monitor compares against the DUT.
module tb_maybe_stream_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic [W-1:0]  in0;
  logic          in1;
  logic          in2;
  logic          out0;
  logic [W-1:0]  out1;
  logic [CW-1:0] out2;
`ifdef MAYBE_STREAM_FIFO_DROP_CNT_EN
  logic [15:0]   out3;
`endif

  maybe_stream_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .__in0  (in0),
    .__in1  (in1),
    .__in2  (in2),
    .__out0 (out0),
    .__out1 (out1),
    .__out2 (out2)
`ifdef MAYBE_STREAM_FIFO_DROP_CNT_EN
    ,
    .__out3 (out3)
`endif
  );

  typedef struct {
    logic         tag;
    logic [W-1:0] data;
    int           cnt;
    int           drops;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: the FIFO contents as a plain queue.
  int   model_q[$];
  int   model_drops = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: every edge's result is compared on the following falling edge.
  always @(negedge clk) begin
    if (rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("out_tag", 32'(out0), 32'(mon_e.tag));
      check("out_data", 32'(out1), 32'(mon_e.data));
      check("occupancy", 32'(out2), 32'(mon_e.cnt));
`ifdef MAYBE_STREAM_FIFO_DROP_CNT_EN
      check("drop_cnt", 32'(out3), 32'(mon_e.drops));
`endif
    end
  end

  // Drive one edge's inputs and push the model's prediction for that edge.
  task automatic step(input logic just, input logic [W-1:0] d, input logic pop);
    exp_t e;
    bit   pop_ok;
    bit   full;
    in1 = just;
    in0 = d;
    in2 = pop;
    full   = (model_q.size() == DEPTH);
    pop_ok = pop && (model_q.size() > 0);
    e.tag  = pop_ok;
    e.data = '0;
    if (pop_ok) e.data = W'(model_q.pop_front());
    if (just) begin
      if (!full || pop_ok) model_q.push_back(int'(d));
      else if (model_drops < 16'hFFFF) model_drops++;
    end
    e.cnt   = model_q.size();
    e.drops = model_drops;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #1;
    in1 = 1'b0;
    in2 = 1'b0;
    in0 = '0;
    rst = 1'b0;
    #1;
    check("rst_tag", 32'(out0), 32'd0);
    check("rst_data", 32'(out1), 32'd0);
    check("rst_occupancy", 32'(out2), 32'd0);
`ifdef MAYBE_STREAM_FIFO_DROP_CNT_EN
    check("rst_drop_cnt", 32'(out3), 32'd0);
`endif
    model_q.delete();
    model_drops = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in0 = '0;
    in1 = 1'b0;
    in2 = 1'b0;
    do_reset();

    // Ordered stream then one pop too many.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // Nothing inputs with a loud payload must be ignored.
    repeat (5) step(1'b0, 8'hAA, 1'b0);
    step(1'b0, 8'hAA, 1'b1);

    // Fill, then push and pop together at full, then drain past empty.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    step(1'b1, 8'hB4, 1'b1);
    repeat (5) step(1'b0, 8'h00, 1'b1);

    // Pointer wrap at occupancy 1.
    step(1'b1, 8'd0, 1'b0);
    for (int i = 1; i < 10; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Drops at full leave contents untouched.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hD0 + i), 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b1);

    // Empty with pop request and concurrent push: stored, count becomes 1.
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Reset mid-stream discards buffered items.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE0 + i), 1'b0);
    do_reset();
    step(1'b0, 8'h00, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45));
    end
    repeat (6) step(1'b0, 8'h00, 1'b1);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
